// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter fed by a small word FIFO; a word accepted at edge E starts on tx at E+2.
// ready drops only while the FIFO is full; frames run back-to-back with no idle gap while words are queued.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 104,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic           PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam logic           PAR_ODD   = (PARITY == 1);
    localparam logic [15:0]    BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]    DEPTH_L   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_nxt;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   full, empty, push, pop;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit, bit_val, bit_end;
    logic [15:0]            baud_cnt;
    logic [3:0]             bit_cnt;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign ready   = rst & ~full;
    assign push    = valid & ready;
    assign busy    = (state != IDLE) | ~empty;
    assign level   = count;
    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    // pop is only raised on registered non-empty, so a word written this edge is never popped this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end && bit_cnt == DATA_LAST) state_nxt = PAR_EN ? PAR : STOP;
            end
            PAR: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) begin
                    if (!empty) begin
                        state_nxt = START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_val = 1'b1;
        case (state)
            START:   bit_val = 1'b0;
            DATA:    bit_val = shreg[0];
            PAR:     bit_val = par_bit;
            default: bit_val = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // baud counter restarts on every bit boundary; bit counter restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            tx <= bit_val;
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 16'd1;
            if (state_nxt != state) bit_cnt <= '0;
            else if (bit_end)       bit_cnt <= bit_cnt + 4'd1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five parameterisations, expected frames queued at stimulus time, decoded from tx by a monitor.
module tb_uart_tx_cfg;
    typedef struct {
        int frame;
        int len;
        int div;
        int start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] dat;
    logic [4:0] vld;
    logic [4:0] rdy, bsy, txv;
    logic [2:0] lvl [5];
    int         cyc = 0;
    int         cur = 0;
    bit         mon_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    int         maxlvl = 0;
    bit         saw_full = 1'b0;
    exp_t       q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .data(dat[7:0]), .valid(vld[0]), .ready(rdy[0]),
        .tx(txv[0]), .busy(bsy[0]), .level(lvl[0]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .data(dat[7:0]), .valid(vld[1]), .ready(rdy[1]),
        .tx(txv[1]), .busy(bsy[1]), .level(lvl[1]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .data(dat[7:0]), .valid(vld[2]), .ready(rdy[2]),
        .tx(txv[2]), .busy(bsy[2]), .level(lvl[2]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .data(dat[6:0]), .valid(vld[3]), .ready(rdy[3]),
        .tx(txv[3]), .busy(bsy[3]), .level(lvl[3]));
    uart_tx_cfg #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst), .data(dat[7:0]), .valid(vld[4]), .ready(rdy[4]),
        .tx(txv[4]), .busy(bsy[4]), .level(lvl[4]));

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic push(input int i, input int d, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        dat    = 9'(d);
        vld[i] = 1'b1;
        while (!rdy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: ready stayed 0 for inst %0d, required 1", i);
        end
        @(posedge clk);
        #1;
        acc    = cyc;
        vld[i] = 1'b0;
    endtask

    task automatic expect_frame(input int frame, input int len, input int div, input int start);
        exp_t e;
        e.frame = frame;
        e.len   = len;
        e.div   = div;
        e.start = start;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && lvl[0] > 3'(maxlvl)) maxlvl = int'(lvl[0]);
        if (rst && vld[0] && !rdy[0]) saw_full = 1'b1;
    end

    initial begin : monitor
        int   idx, t0, got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst && txv[cur] == 1'b0) begin
                idx = cur;
                t0  = cyc;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: start bit on inst %0d at cycle %0d, required none", idx, t0);
                    repeat (48) @(negedge clk);
                end else begin
                    e   = q.pop_front();
                    got = 0;
                    repeat (e.div / 2) @(negedge clk);
                    for (int b = 0; b < e.len; b++) begin
                        got |= int'(txv[idx]) << b;
                        if (b != e.len - 1) repeat (e.div) @(negedge clk);
                    end
                    chk("frame_bits", got, e.frame);
                    if (e.start >= 0) chk("frame_start", t0, e.start);
                    repeat (e.div - e.div / 2 - 1) @(negedge clk);
                end
            end
        end
    end

    initial begin : stim
        int acc, s, s0, hi, n;
        int words [6];
        int frames [6];
        words  = '{'h11, 'h22, 'h33, 'h44, 'h5A, 'hC3};
        frames = '{'h222, 'h244, 'h266, 'h288, 'h2B4, 'h386};
        rst = 1'b0;
        vld = '0;
        dat = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("rst_tx", txv[i], 1);
            chk("rst_ready", rdy[i], 0);
            chk("rst_busy", bsy[i], 0);
            chk("rst_level", lvl[i], 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // 8N1 0x55 on the first edge after reset release
        cur = 0;
        push(0, 'h55, acc);
        chk("first_edge_level", lvl[0], 1);
        s = acc + 2;
        expect_frame('h2AA, 10, 4, s);
        wait_until(s + 5);
        chk("busy_in_frame", bsy[0], 1);
        wait_until(s + 41);
        chk("idle_busy", bsy[0], 0);
        chk("idle_tx", txv[0], 1);
        chk("idle_level", lvl[0], 0);

        // six words back-to-back into a depth-4 FIFO
        maxlvl   = 0;
        saw_full = 1'b0;
        push(0, words[0], acc);
        s0 = acc + 2;
        expect_frame(frames[0], 10, 4, s0);
        for (int k = 1; k < 6; k++) begin
            push(0, words[k], acc);
            expect_frame(frames[k], 10, 4, s0 + 40 * k);
        end
        wait_until(s0 + 242);
        chk("max_level", maxlvl, 4);
        chk("ready_dropped", int'(saw_full), 1);
        chk("fifo_busy_done", bsy[0], 0);

        // push into an empty FIFO while the frame is in its stop bit
        push(0, 'h81, acc);
        s = acc + 2;
        expect_frame('h302, 10, 4, s);
        wait_until(s + 35);
        chk("empty_before_push", lvl[0], 0);
        push(0, 'h0F, acc);
        chk("push_in_stop", acc, s + 37);
        expect_frame('h21E, 10, 4, s + 40);
        wait_until(s + 85);
        chk("drain_before_reset", q.size(), 0);

        // reset mid-DATA with two words still queued
        mon_en = 1'b0;
        push(0, 'h00, acc);
        s = acc + 2;
        push(0, 'h00, acc);
        push(0, 'h00, acc);
        wait_until(s + 12);
        chk("level_queued", lvl[0], 2);
        chk("pre_rst_tx", txv[0], 0);
        #2 rst = 1'b0;
        #1;
        chk("async_tx", txv[0], 1);
        chk("rst_level_mid", lvl[0], 0);
        chk("rst_ready_mid", rdy[0], 0);
        chk("rst_busy_mid", bsy[0], 0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (txv[0]) hi++;
        end
        chk("no_residual", hi, 60);
        chk("post_rst_level", lvl[0], 0);
        chk("post_rst_busy", bsy[0], 0);

        // parity variants
        cur = 1;
        push(1, 'h07, acc);
        expect_frame('h60E, 11, 4, acc + 2);
        wait_until(acc + 48);
        cur = 2;
        push(2, 'h07, acc);
        expect_frame('h40E, 11, 4, acc + 2);
        wait_until(acc + 48);
        cur = 3;
        push(3, 'h7F, acc);
        expect_frame('h3FE, 10, 4, acc + 2);
        wait_until(acc + 44);

        // two stop bits at CLK_DIV=3, two frames back-to-back
        cur = 4;
        push(4, 'hA5, acc);
        s = acc + 2;
        expect_frame('h74A, 11, 3, s);
        push(4, 'h3C, acc);
        expect_frame('h678, 11, 3, s + 33);
        wait_until(s + 26);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (txv[4]) hi++;
        end
        chk("stop_run", hi, 6);
        @(negedge clk);
        chk("frame2_start_low", txv[4], 0);
        wait_until(s + 70);

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
